// File: rtl/arbiter.sv
// arbiter: non-preemptive priority arbiter for the DMA channels.
// Highest priority level wins, ties are broken round-robin, and the grant is held until the owner drops its request.
`default_nettype none

module arbiter #(
  parameter int DMA_CH = 8
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req_i            [DMA_CH],
  input  logic [3:0] priority_level_i [DMA_CH],
  output logic       grant_o          [DMA_CH]
);

  localparam int IDX_W = $clog2(DMA_CH);

  logic [DMA_CH-1:0] req_v;
  logic [DMA_CH-1:0] grant_q, grant_d;
  logic              owner_valid_q, owner_valid_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              any_req;
  logic              found;
  logic [3:0]        max_pri;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  cidx;
  int                cand;

  for (genvar g = 0; g < DMA_CH; g++) begin : g_ports
    assign req_v[g]   = req_i[g];
    assign grant_o[g] = grant_q[g];
  end

  // Find the highest requested priority, then the first requester at that
  // level when searching from the channel after the last one granted.
  always_comb begin
    any_req = 1'b0;
    max_pri = '0;
    for (int i = 0; i < DMA_CH; i++) begin
      if (req_v[i]) begin
        any_req = 1'b1;
        if (priority_level_i[i] > max_pri) max_pri = priority_level_i[i];
      end
    end

    winner = ptr_q;
    found  = 1'b0;
    cand   = 0;
    cidx   = '0;
    for (int k = 1; k <= DMA_CH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= DMA_CH) cand = cand - DMA_CH;
      cidx = IDX_W'(cand);
      if (!found && req_v[cidx] && (priority_level_i[cidx] == max_pri)) begin
        winner = cidx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d       = grant_q;
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;

    if (owner_valid_q && req_v[owner_q]) begin
      grant_d = grant_q;
    end else if (any_req) begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      owner_valid_d   = 1'b1;
      owner_d         = winner;
      ptr_d           = winner;
    end else begin
      grant_d       = '0;
      owner_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      grant_q       <= '0;
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
      ptr_q         <= IDX_W'(DMA_CH - 1);
    end else begin
      grant_q       <= grant_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbiter.sv
// tb_arbiter: directed checks of grant ordering, round-robin ties, hold and reset for arbiter.
`default_nettype none

module tb_arbiter;

  localparam int N = 8;

  logic       clk_i;
  logic       rstn_i;
  logic       req_i            [N];
  logic [3:0] priority_level_i [N];
  logic       grant_o          [N];
  logic [N-1:0] gv;
  logic [N-1:0] req_m;

  int checks;
  int failures;

  arbiter #(.DMA_CH(N)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_i            (req_i),
    .priority_level_i (priority_level_i),
    .grant_o          (grant_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_comb begin
    gv = '0;
    for (int i = 0; i < N; i++) gv[i] = grant_o[i];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic [N-1:0] m);
    req_m = m;
    for (int i = 0; i < N; i++) req_i[i] = m[i];
  endtask

  task automatic set_pri_index();
    for (int i = 0; i < N; i++) priority_level_i[i] = 4'(i);
  endtask

  task automatic set_pri_zero();
    for (int i = 0; i < N; i++) priority_level_i[i] = 4'd0;
  endtask

  // Inputs change on the falling edge; results are read one falling edge later.
  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    set_req('0);
    rstn_i = 1'b0;
    step();
    check("reset_grant", 32'(gv), 32'h0);
    rstn_i = 1'b1;
  endtask

  task automatic drop(input int ch);
    req_m[ch] = 1'b0;
    set_req(req_m);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn_i   = 1'b0;
    set_req('0);
    set_pri_zero();
    @(negedge clk_i);

    // Priority ordering: 6 -> 2 -> 1 -> 0, two cycles each, no gaps.
    set_pri_index();
    do_reset();
    set_req(8'h47);
    step();
    begin
      int order [4] = '{6, 2, 1, 0};
      for (int j = 0; j < 4; j++) begin
        check($sformatf("prio_ch%0d_c1", order[j]), 32'(gv), 32'(1) << order[j]);
        step();
        check($sformatf("prio_ch%0d_c2", order[j]), 32'(gv), 32'(1) << order[j]);
        drop(order[j]);
        step();
      end
    end
    check("prio_idle", 32'(gv), 32'h0);

    // Round-robin tie among equal priorities.
    set_pri_zero();
    do_reset();
    set_req(8'h07);
    step();
    check("rr_first0", 32'(gv), 32'h01);
    drop(0); step();
    check("rr_then1", 32'(gv), 32'h02);
    drop(1); step();
    check("rr_then2", 32'(gv), 32'h04);
    drop(2); step();
    check("rr_idle", 32'(gv), 32'h0);
    set_req(8'h05);
    step();
    check("rr_wrap0", 32'(gv), 32'h01);
    drop(0); step();
    check("rr_wrap2", 32'(gv), 32'h04);
    drop(2); step();

    // Non-preemption: higher request arrives while channel 1 holds.
    set_pri_index();
    do_reset();
    set_req(8'h02);
    step();
    check("np_own1", 32'(gv), 32'h02);
    set_req(8'h82);
    step();
    check("np_hold1a", 32'(gv), 32'h02);
    step();
    check("np_hold1b", 32'(gv), 32'h02);
    drop(1); step();
    check("np_to7", 32'(gv), 32'h80);
    drop(7); step();
    check("np_idle", 32'(gv), 32'h0);

    // Late arrivals during channel 2's grant.
    do_reset();
    set_req(8'h05);
    step();
    check("late_own2", 32'(gv), 32'h04);
    set_req(8'hA5);
    step();
    check("late_hold2", 32'(gv), 32'h04);
    drop(2); step();
    for (int c = 0; c < 6; c++) begin
      check("late_ch7", 32'(gv), 32'h80);
      if (c < 5) step();
    end
    drop(7); step();
    for (int c = 0; c < 6; c++) begin
      check("late_ch5", 32'(gv), 32'h20);
      if (c < 5) step();
    end
    drop(5); step();
    check("late_ch0", 32'(gv), 32'h01);
    drop(0); step();
    check("late_idle", 32'(gv), 32'h0);

    // Idle and latency on a single request.
    do_reset();
    step();
    check("lat_none", 32'(gv), 32'h0);
    set_req(8'h08);
    step();
    check("lat_on", 32'(gv), 32'h08);
    step(); step();
    check("lat_hold", 32'(gv), 32'h08);
    drop(3); step();
    check("lat_off", 32'(gv), 32'h0);

    // Reset while channel 4 owns the grant.
    do_reset();
    set_req(8'h10);
    step();
    check("rst_own4", 32'(gv), 32'h10);
    rstn_i = 1'b0;
    step();
    check("rst_drop", 32'(gv), 32'h0);
    rstn_i = 1'b1;
    step();
    check("rst_regrant4", 32'(gv), 32'h10);
    set_req('0);
    step();
    check("rst_final_idle", 32'(gv), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Any single grant vector with more than one bit set is a fault.
  always @(negedge clk_i) begin
    if ($countones(gv) > 1) begin
      failures++;
      checks++;
      $display("FAIL onehot: got 0x%0h expected at most one bit", gv);
    end
  end

endmodule

`default_nettype wire
